// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - frame, stage and result channels of the FFT stage sequencer
interface fft_stage_sequencer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);
  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam int CFG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  // Input frame from the sample source
  logic [BIT_WIDTH-1:0] recv_msg_real [N_SAMPLES];
  logic [BIT_WIDTH-1:0] recv_msg_imag [N_SAMPLES];
  logic                 recv_val;
  logic                 recv_rdy;

  // Finished frame to downstream logic
  logic [BIT_WIDTH-1:0] send_msg_real [N_SAMPLES];
  logic [BIT_WIDTH-1:0] send_msg_imag [N_SAMPLES];
  logic                 send_val;
  logic                 send_rdy;

  // Frame into the shared stage datapath
  logic [BIT_WIDTH-1:0] stage_send_real [N_SAMPLES];
  logic [BIT_WIDTH-1:0] stage_send_imag [N_SAMPLES];
  logic                 stage_send_val;
  logic                 stage_send_rdy;
  logic [CFG_W-1:0]     stage_cfg;

  // Pass result back from the shared stage datapath
  logic [BIT_WIDTH-1:0] stage_recv_real [N_SAMPLES];
  logic [BIT_WIDTH-1:0] stage_recv_imag [N_SAMPLES];
  logic                 stage_recv_val;
  logic                 stage_recv_rdy;

  logic                 busy;

  // Sequencer side
  modport master (
    input  recv_msg_real, recv_msg_imag, recv_val,
    output recv_rdy,
    output send_msg_real, send_msg_imag, send_val,
    input  send_rdy,
    output stage_send_real, stage_send_imag, stage_send_val, stage_cfg,
    input  stage_send_rdy,
    input  stage_recv_real, stage_recv_imag, stage_recv_val,
    output stage_recv_rdy,
    output busy
  );

  // Source, sink and stage datapath side
  modport slave (
    output recv_msg_real, recv_msg_imag, recv_val,
    input  recv_rdy,
    input  send_msg_real, send_msg_imag, send_val,
    output send_rdy,
    input  stage_send_real, stage_send_imag, stage_send_val, stage_cfg,
    output stage_send_rdy,
    output stage_recv_real, stage_recv_imag, stage_recv_val,
    input  stage_recv_rdy,
    input  busy
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - iterative FFT controller looping one shared stage over log2(N) passes
module fft_stage_sequencer #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8,
  parameter int LOG2N      = $clog2(N_SAMPLES)
) (
  input  logic                   clk,
  input  logic                   reset,
  fft_stage_sequencer_if.master  bus
);
  localparam int CFG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam logic [CFG_W-1:0] LAST_STAGE = CFG_W'(LOG2N - 1);

  // Data is passed through untouched; the fixed-point format only has to be sane
  if (DECIMAL_PT > BIT_WIDTH) begin : g_bad_decimal_pt
    $error("DECIMAL_PT must not exceed BIT_WIDTH");
  end
  if (N_SAMPLES < 4 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n_samples
    $error("N_SAMPLES must be a power of two of at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [CFG_W-1:0]     stage_q;
  logic                 recv_rdy_q;
  logic                 send_val_q;
  logic                 stage_send_val_q;
  logic                 stage_recv_rdy_q;
  logic                 busy_q;
  logic [BIT_WIDTH-1:0] buf_real_q [N_SAMPLES];
  logic [BIT_WIDTH-1:0] buf_imag_q [N_SAMPLES];

  // Pass sequencing; every handshake output is a flop set on the transition into its state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      stage_q          <= '0;
      recv_rdy_q       <= 1'b1;
      send_val_q       <= 1'b0;
      stage_send_val_q <= 1'b0;
      stage_recv_rdy_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.recv_val) begin
            state_q          <= S_ISSUE;
            stage_q          <= '0;
            recv_rdy_q       <= 1'b0;
            stage_send_val_q <= 1'b1;
            busy_q           <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.stage_send_rdy) begin
            state_q          <= S_WAIT;
            stage_send_val_q <= 1'b0;
            stage_recv_rdy_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.stage_recv_val) begin
            stage_recv_rdy_q <= 1'b0;
            if (stage_q == LAST_STAGE) begin
              state_q    <= S_DONE;
              send_val_q <= 1'b1;
            end else begin
              state_q          <= S_ISSUE;
              stage_q          <= stage_q + CFG_W'(1);
              stage_send_val_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.send_rdy) begin
            state_q    <= S_IDLE;
            send_val_q <= 1'b0;
            recv_rdy_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q          <= S_IDLE;
          stage_q          <= '0;
          recv_rdy_q       <= 1'b1;
          send_val_q       <= 1'b0;
          stage_send_val_q <= 1'b0;
          stage_recv_rdy_q <= 1'b0;
          busy_q           <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer: loaded on accept, overwritten by each pass result, frozen otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_real_q <= '{default: '0};
      buf_imag_q <= '{default: '0};
    end else if (state_q == S_IDLE && bus.recv_val) begin
      buf_real_q <= bus.recv_msg_real;
      buf_imag_q <= bus.recv_msg_imag;
    end else if (state_q == S_WAIT && bus.stage_recv_val) begin
      buf_real_q <= bus.stage_recv_real;
      buf_imag_q <= bus.stage_recv_imag;
    end
  end

  assign bus.recv_rdy        = recv_rdy_q;
  assign bus.send_val        = send_val_q;
  assign bus.stage_send_val  = stage_send_val_q;
  assign bus.stage_recv_rdy  = stage_recv_rdy_q;
  assign bus.stage_cfg       = stage_q;
  assign bus.busy            = busy_q;
  assign bus.send_msg_real   = buf_real_q;
  assign bus.send_msg_imag   = buf_imag_q;
  assign bus.stage_send_real = buf_real_q;
  assign bus.stage_send_imag = buf_imag_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;
  localparam int BW    = 32;
  localparam int NS    = 8;
  localparam int LOG2N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) bus ();

  fft_stage_sequencer #(
    .BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(NS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stub stage: adds (stage_cfg+1)<<16 to every real word, with per-pass stall knobs
  int issue_stall [LOG2N];
  int resp_delay  [LOG2N];
  bit spurious;
  int iss_cnt = 0;
  int rsp_cnt = 0;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      if (spurious && !bus.stage_recv_rdy) begin
        bus.stage_recv_real[i] = 32'hDEADBEEF;
        bus.stage_recv_imag[i] = 32'hDEADBEEF;
      end else begin
        bus.stage_recv_real[i] = bus.stage_send_real[i] + ((32'(bus.stage_cfg) + 32'd1) << 16);
        bus.stage_recv_imag[i] = bus.stage_send_imag[i];
      end
    end
  end

  always @(negedge clk) begin
    if (bus.stage_send_val) begin
      if (iss_cnt < issue_stall[bus.stage_cfg]) begin
        bus.stage_send_rdy = 1'b0;
        iss_cnt++;
      end else begin
        bus.stage_send_rdy = 1'b1;
      end
    end else begin
      iss_cnt = 0;
      bus.stage_send_rdy = 1'b1;
    end
    if (bus.stage_recv_rdy) begin
      if (rsp_cnt < resp_delay[bus.stage_cfg]) begin
        bus.stage_recv_val = 1'b0;
        rsp_cnt++;
      end else begin
        bus.stage_recv_val = 1'b1;
      end
    end else begin
      rsp_cnt = 0;
      bus.stage_recv_val = spurious;
    end
  end

  // Event monitor, sampled just before each rising edge
  int   out_cnt = 0;
  int   acc_cnt = 0;
  int   viol    = 0;
  logic [1:0] cfg_log [$];
  logic       prev_ssv = 1'b0;
  logic       prev_srr = 1'b0;
  logic [1:0] prev_cfg = '0;
  logic [BW-1:0] prev_real [NS];

  always @(negedge clk) begin
    #3;
    if (bus.send_val && bus.send_rdy) out_cnt++;
    if (bus.recv_val && bus.recv_rdy) acc_cnt++;
    if (bus.stage_send_val && bus.stage_send_rdy) cfg_log.push_back(bus.stage_cfg);
    if ((bus.stage_send_val && prev_ssv) || (bus.stage_recv_rdy && prev_srr)) begin
      if (bus.stage_cfg != prev_cfg) viol++;
      for (int i = 0; i < NS; i++) if (bus.stage_send_real[i] != prev_real[i]) viol++;
    end
    prev_ssv = bus.stage_send_val;
    prev_srr = bus.stage_recv_rdy;
    prev_cfg = bus.stage_cfg;
    for (int i = 0; i < NS; i++) prev_real[i] = bus.stage_send_real[i];
  end

  task automatic check_frame(input string tag, input logic [31:0] rexp);
    for (int i = 0; i < NS; i++) begin
      check($sformatf("%s_real%0d", tag, i), bus.send_msg_real[i], rexp);
      check($sformatf("%s_imag%0d", tag, i), bus.send_msg_imag[i], 32'd0);
    end
  endtask

  task automatic load_frame(input logic [31:0] rin);
    for (int i = 0; i < NS; i++) begin
      bus.recv_msg_real[i] = rin;
      bus.recv_msg_imag[i] = '0;
    end
  endtask

  // One frame end to end; lat = edges from accept to the first edge that can fire send
  task automatic run_frame(input string tag, input logic [31:0] rin, input logic [31:0] rexp,
                           input int hold, output int lat);
    int cnt;
    @(negedge clk);
    load_frame(rin);
    bus.recv_val = 1'b1;
    bus.send_rdy = (hold == 0);
    cnt = 0;
    while (!bus.recv_rdy && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_accept_rdy"}, bus.recv_rdy, 1'b1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) bus.recv_val = 1'b0;
    end while (!bus.send_val && cnt < 100);
    lat = cnt;
    check_frame(tag, rexp);
    check({tag, "_done_recv_rdy"}, bus.recv_rdy, 1'b0);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_send_val"}, bus.send_val, 1'b1);
      check({tag, "_hold_data"}, bus.send_msg_real[NS-1], rexp);
      check({tag, "_hold_recv_rdy"}, bus.recv_rdy, 1'b0);
    end
    bus.send_rdy = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_post_recv_rdy"}, bus.recv_rdy, 1'b1);
    check({tag, "_post_send_val"}, bus.send_val, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    int out0;
    int acc0;
    reset        = 1'b1;
    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b1;
    spurious     = 1'b0;
    for (int i = 0; i < LOG2N; i++) begin
      issue_stall[i] = 0;
      resp_delay[i]  = 0;
    end
    load_frame('0);
    repeat (3) @(negedge clk);
    check("rst_recv_rdy", bus.recv_rdy, 1'b1);
    check("rst_send_val", bus.send_val, 1'b0);
    check("rst_stage_send_val", bus.stage_send_val, 1'b0);
    check("rst_stage_recv_rdy", bus.stage_recv_rdy, 1'b0);
    check("rst_stage_cfg", bus.stage_cfg, 2'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_buf", bus.send_msg_real[0], 32'd0);
    reset = 1'b0;

    // Single frame, stage always ready
    cfg_log.delete();
    run_frame("f1", 32'h0001_0000, 32'h0007_0000, 0, lat);
    check("f1_latency", lat, 7);
    check("f1_cfg_count", cfg_log.size(), 3);
    for (int i = 0; i < 3 && i < cfg_log.size(); i++)
      check($sformatf("f1_cfg%0d", i), cfg_log[i], i);

    // Stalls on the stage handshakes
    issue_stall[1] = 3;
    resp_delay[2]  = 2;
    viol = 0;
    run_frame("stall", 32'h0001_0000, 32'h0007_0000, 0, lat);
    check("stall_latency", lat, 12);
    check("stall_stability", viol, 0);
    issue_stall[1] = 0;
    resp_delay[2]  = 0;

    // Downstream backpressure in DONE
    out0 = out_cnt;
    run_frame("bp", 32'h0001_0000, 32'h0007_0000, 5, lat);
    check("bp_out_count", out_cnt - out0, 1);

    // Back-to-back frames with recv_val held high
    out0 = out_cnt;
    acc0 = acc_cnt;
    @(negedge clk);
    load_frame(32'h0001_0000);
    bus.recv_val = 1'b1;
    bus.send_rdy = 1'b1;
    @(negedge clk);
    load_frame(32'h0002_0000);
    cnt = 0;
    while (!bus.send_val && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_frame("b2b1", 32'h0007_0000);
    check("b2b_done_recv_rdy", bus.recv_rdy, 1'b0);
    @(negedge clk);
    check("b2b_idle_recv_rdy", bus.recv_rdy, 1'b1);
    @(negedge clk);
    bus.recv_val = 1'b0;
    cnt = 0;
    while (!bus.send_val && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_frame("b2b2", 32'h0008_0000);
    repeat (4) @(negedge clk);
    check("b2b_out_count", out_cnt - out0, 2);
    check("b2b_acc_count", acc_cnt - acc0, 2);

    // Reset during the wait of pass 1
    resp_delay[1] = 6;
    out0 = out_cnt;
    @(negedge clk);
    load_frame(32'h0001_0000);
    bus.recv_val = 1'b1;
    @(negedge clk);
    bus.recv_val = 1'b0;
    cnt = 0;
    while (!(bus.stage_recv_rdy && bus.stage_cfg == 2'd1) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("rstmid_reached_wait1", bus.stage_cfg, 2'd1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", bus.busy, 1'b0);
    check("rstmid_recv_rdy", bus.recv_rdy, 1'b1);
    check("rstmid_stage_cfg", bus.stage_cfg, 2'd0);
    check("rstmid_send_val", bus.send_val, 1'b0);
    check("rstmid_buf", bus.send_msg_real[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp_delay[1] = 0;
    repeat (2) @(negedge clk);
    check("rstmid_no_output", out_cnt - out0, 0);
    run_frame("rstmid_fresh", 32'h0001_0000, 32'h0007_0000, 0, lat);
    check("rstmid_fresh_latency", lat, 7);

    // Spurious stage response during ISSUE
    spurious = 1'b1;
    run_frame("spur", 32'h0001_0000, 32'h0007_0000, 0, lat);
    check("spur_latency", lat, 7);
    spurious = 1'b0;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Iterative FFT controller: accepts one N-sample complex frame, then time-multiplexes a single runtime-configurable FFT stage datapath over log2(N) passes, looping each pass result back through an internal frame buffer.
- Emits the finished frame on a val/rdy output.
- Sits between the sample source (e.g. deserializer) and downstream magnitude/classifier logic.
- Replaces a chain of log2(N) hardwired stages when area matters more than throughput.

Parameters:
- BIT_WIDTH, 32, width of each real/imag fixed-point word.
- DECIMAL_PT, 16, fractional bits. Informational only; the sequencer does no arithmetic on data.
- N_SAMPLES, 8, frame size. Power of two, ≥ 4.
- LOG2N, $clog2(N_SAMPLES), number of passes. Derived; do not override.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- recv_msg_real, in, BIT_WIDTH x N_SAMPLES (unpacked), input frame, real parts.
- recv_msg_imag, in, BIT_WIDTH x N_SAMPLES, input frame, imag parts.
- recv_val / recv_rdy, in / out, 1, input frame handshake.
- send_msg_real, out, BIT_WIDTH x N_SAMPLES, result frame, real parts.
- send_msg_imag, out, BIT_WIDTH x N_SAMPLES, result frame, imag parts.
- send_val / send_rdy, out / in, 1, output frame handshake.
- stage_send_real, out, BIT_WIDTH x N_SAMPLES, frame to the shared stage.
- stage_send_imag, out, BIT_WIDTH x N_SAMPLES, frame to the shared stage.
- stage_send_val / stage_send_rdy, out / in, 1, handshake into the stage.
- stage_cfg, out, $clog2(LOG2N) (min 1), current stage index driven to the datapath.
- stage_recv_real, in, BIT_WIDTH x N_SAMPLES, stage result.
- stage_recv_imag, in, BIT_WIDTH x N_SAMPLES, stage result.
- stage_recv_val / stage_recv_rdy, in / out, 1, handshake from the stage.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset effect: FSM goes to IDLE; buffer (real/imag) cleared to 0; stage counter = 0.
- Reset output values: recv_rdy=1, send_val=0, stage_send_val=0, stage_recv_rdy=0, stage_cfg=0, busy=0.
- Data outputs: send_msg_* and stage_send_* both drive the buffer directly at all times.
- States:
  - IDLE: recv_rdy=1. On recv_val: latch the frame into the buffer, set stage=0, go to ISSUE.
  - ISSUE: stage_send_val=1, stage_cfg=stage. On stage_send_rdy go to WAIT; otherwise hold.
  - WAIT: stage_recv_rdy=1, stage_cfg is held. On stage_recv_val, overwrite the buffer with stage_recv_*.
    - If stage==LOG2N-1: go to DONE.
    - Otherwise: stage+1, go to ISSUE.
  - DONE: send_val=1. On send_rdy go to IDLE.
- Handshake rules:
  - All handshakes transfer on the rising edge where val&&rdy.
  - All rdy/val outputs are decoded from the registered state only; no combinational val→rdy paths.
  - recv_rdy is low outside IDLE. No overlap: a new frame is accepted no earlier than the cycle after the send fires.
- Latency: minimum accept-edge to send_val-high = 2*LOG2N+1 cycles (7 for N=8), assuming the stage takes ISSUE immediately and returns stage_recv_val on the first WAIT cycle.
- Throughput: at most one frame per 2*LOG2N+2 cycles.
- Stalls:
  - stage_send_rdy low holds ISSUE; stage_recv_val low holds WAIT; send_rdy low holds DONE.
  - The buffer and stage_cfg are stable during every stall.
- Boundary conditions:
  - stage_recv_val while in ISSUE is ignored (stage_recv_rdy=0).
  - stage_cfg never exceeds LOG2N-1 and does not wrap mid-frame.
  - Reset asserted mid-pass aborts the frame. No output fires and the partial buffer is discarded.
  - recv_val held high in DONE is not accepted until IDLE.

Test Plan:
- Single frame, N=8, always-ready stub stage that adds (stage_cfg+1)<<16 to every real word. Input real=0x00010000, imag=0 → send_val after 7 cycles; all real=0x00070000, all imag=0; stage_cfg sequence 0,1,2.
- Stub holds stage_send_rdy low 3 cycles on pass 1 and delays stage_recv_val 2 cycles on pass 2 → same final data; stage_cfg and stage_send_* stable during stalls; latency 12.
- send_rdy low 5 cycles in DONE → send_val and send_msg held; recv_rdy=0 throughout; accept fires on send_rdy; recv_rdy=1 the next cycle.
- Back-to-back frames with recv_val held high; second frame input real=0x00020000 → second output real=0x00080000; exactly 2 outputs; no frame dropped or duplicated.
- Reset pulsed during WAIT of pass 1 → immediately busy=0, recv_rdy=1, stage_cfg=0, send_val=0; a fresh frame afterwards produces the correct 0x00070000 result.
- Spurious stage_recv_val=1 with data 0xDEADBEEF during ISSUE → ignored; final result unchanged.
